// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the program counter, drives the word address
// into a combinational-read instruction memory, and captures the returned
// instruction into the IF/ID pipeline register for the decode stage.
// Edge priority is reset > redirect > stall > advance. A redirect always
// leaves exactly one bubble in IF/ID.
module instruction_fetch_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_target,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_pc_plus4,
  output logic [DATA_WIDTH-1:0] if_instruction,
  output logic                  if_valid,
  output logic                  misaligned_error,
  output logic [31:0]           fetch_count
);

  logic [31:0]           r_pc;
  logic [31:0]           r_if_pc;
  logic [31:0]           r_if_pc_plus4;
  logic [DATA_WIDTH-1:0] r_if_instruction;
  logic                  r_if_valid;
  logic                  r_misaligned_error;
  logic [31:0]           r_fetch_count;

  logic [31:0]           w_pc_plus4;
  logic [31:0]           w_target_aligned;
  logic                  w_target_misaligned;

  // Next sequential PC and the aligned redirect destination; both wrap mod 2^32.
  always_comb begin
    // NOTE: every combinational output is assigned on every path, so no latch can be inferred.
    w_pc_plus4          = r_pc + 32'd4;
    w_target_aligned    = {redirect_target[31:2], 2'b00};
    w_target_misaligned = |redirect_target[1:0];
  end

  // PC and IF/ID register update in priority order: reset, redirect, stall, advance.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    if (reset) begin
      r_pc               <= RESET_PC;
      r_if_pc            <= '0;
      r_if_pc_plus4      <= '0;
      r_if_instruction   <= '0;
      r_if_valid         <= 1'b0;
      r_misaligned_error <= 1'b0;
      r_fetch_count      <= '0;
    end else if (redirect_valid) begin
      // The instruction currently being read is on the wrong path: drop it
      // by inserting a bubble; the IF/ID payload keeps its old contents.
      r_pc       <= w_target_aligned;
      r_if_valid <= 1'b0;
      if (w_target_misaligned) begin
        r_misaligned_error <= 1'b1;
      end
    end else if (!stall) begin
      r_if_pc          <= r_pc;
      r_if_pc_plus4    <= w_pc_plus4;
      r_if_instruction <= instruction;
      r_if_valid       <= 1'b1;
      r_pc             <= w_pc_plus4;
      r_fetch_count    <= r_fetch_count + 32'd1;
    end
  end

  // Memory address comes straight from the PC register; high PC bits alias.
  assign read_address     = r_pc[ADDR_WIDTH+1:2];

  assign if_pc            = r_if_pc;
  assign if_pc_plus4      = r_if_pc_plus4;
  assign if_instruction   = r_if_instruction;
  assign if_valid         = r_if_valid;
  assign misaligned_error = r_misaligned_error;
  assign fetch_count      = r_fetch_count;

  // The two low PC bits never address memory; keep them visibly consumed.
  logic w_unused_pc_low;
  assign w_unused_pc_low = ^{r_pc[1:0], r_pc[31:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage. A behavioural ROM holds
// word i = 32'hC0DE_0000 | i, so expected instructions follow directly
// from the expected word address.
module tb_instruction_fetch_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_target;
  logic [AW-1:0] read_address;
  logic [DW-1:0] instruction;
  logic [31:0]   if_pc;
  logic [31:0]   if_pc_plus4;
  logic [DW-1:0] if_instruction;
  logic          if_valid;
  logic          misaligned_error;
  logic [31:0]   fetch_count;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  instruction_fetch_stage #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .read_address    (read_address),
    .instruction     (instruction),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4),
    .if_instruction  (if_instruction),
    .if_valid        (if_valid),
    .misaligned_error(misaligned_error),
    .fetch_count     (fetch_count)
  );

  always #5 clock = ~clock;

  // Combinational-read instruction memory.
  assign instruction = mem[read_address];

  // One rising edge, then settle 1 time unit so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", if_valid); end
    total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
    total++; if (read_address !== 10'd0) begin bad++; $display("FAIL reset_raddr got=%0d exp=0", read_address); end
    total++; if (if_pc !== 32'd0 || if_pc_plus4 !== 32'd0 || if_instruction !== 32'd0) begin
      bad++; $display("FAIL reset_ifid got pc=%h p4=%h ins=%h exp all 0", if_pc, if_pc_plus4, if_instruction); end
    total++; if (misaligned_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", misaligned_error); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc  [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] exp_ins [3] = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (if_pc !== exp_pc[i] || if_pc_plus4 !== exp_pc[i] + 32'd4 ||
          if_instruction !== exp_ins[i] || if_valid !== 1'b1) begin
        bad++;
        $display("FAIL seq_%0d got pc=%h p4=%h ins=%h v=%0b exp pc=%h p4=%h ins=%h v=1",
                 i, if_pc, if_pc_plus4, if_instruction, if_valid, exp_pc[i], exp_pc[i] + 32'd4, exp_ins[i]);
      end
    end
    total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL seq_count got=%0d exp=3", fetch_count); end
    total++; if (read_address !== 10'd3) begin bad++; $display("FAIL seq_raddr got=%0d exp=3", read_address); end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (if_pc !== 32'h4 || if_instruction !== 32'hC0DE_0001 || fetch_count !== 32'd2 ||
          read_address !== 10'd2 || if_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold_%0d got pc=%h ins=%h cnt=%0d ra=%0d v=%0b exp pc=4 ins=c0de0001 cnt=2 ra=2 v=1",
                 i, if_pc, if_instruction, fetch_count, read_address, if_valid);
      end
    end
    stall = 1'b0;
    step();
    total++;
    if (if_pc !== 32'h8 || if_instruction !== 32'hC0DE_0002 || fetch_count !== 32'd3) begin
      bad++;
      $display("FAIL stall_release got pc=%h ins=%h cnt=%0d exp pc=8 ins=c0de0002 cnt=3", if_pc, if_instruction, fetch_count);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step(); step();
    redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
    total++;
    if (if_valid !== 1'b0 || read_address !== 10'd16 || fetch_count !== 32'd2 ||
        if_pc !== 32'h4 || if_instruction !== 32'hC0DE_0001) begin
      bad++;
      $display("FAIL redir_bubble got v=%0b ra=%0d cnt=%0d pc=%h ins=%h exp v=0 ra=16 cnt=2 pc=4 ins=c0de0001",
               if_valid, read_address, fetch_count, if_pc, if_instruction);
    end
    step();
    total++;
    if (if_pc !== 32'h40 || if_pc_plus4 !== 32'h44 || if_instruction !== 32'hC0DE_0010 ||
        if_valid !== 1'b1 || fetch_count !== 32'd3) begin
      bad++;
      $display("FAIL redir_target got pc=%h p4=%h ins=%h v=%0b cnt=%0d exp pc=40 p4=44 ins=c0de0010 v=1 cnt=3",
               if_pc, if_pc_plus4, if_instruction, if_valid, fetch_count);
    end
  endtask

  // Continues from the state left by test_redirect (if_pc = 0x40, pc = 0x44).
  task automatic test_redirect_and_stall();
    redirect_valid = 1'b1; stall = 1'b1; redirect_target = 32'h20;
    step();
    redirect_valid = 1'b0;
    total++;
    if (read_address !== 10'd8 || if_valid !== 1'b0 || fetch_count !== 32'd3) begin
      bad++;
      $display("FAIL rs_redirect_wins got ra=%0d v=%0b cnt=%0d exp ra=8 v=0 cnt=3", read_address, if_valid, fetch_count);
    end
    step();
    total++;
    if (read_address !== 10'd8 || if_valid !== 1'b0 || fetch_count !== 32'd3) begin
      bad++;
      $display("FAIL rs_stall_bubble got ra=%0d v=%0b cnt=%0d exp ra=8 v=0 cnt=3", read_address, if_valid, fetch_count);
    end
    stall = 1'b0;
    step();
    total++;
    if (if_pc !== 32'h20 || if_instruction !== 32'hC0DE_0008 || if_valid !== 1'b1) begin
      bad++;
      $display("FAIL rs_release got pc=%h ins=%h v=%0b exp pc=20 ins=c0de0008 v=1", if_pc, if_instruction, if_valid);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    step();
    redirect_valid = 1'b1; redirect_target = 32'h23;
    step();
    redirect_valid = 1'b0;
    total++;
    if (read_address !== 10'd8 || misaligned_error !== 1'b1) begin
      bad++;
      $display("FAIL mis_set got ra=%0d err=%0b exp ra=8 err=1", read_address, misaligned_error);
    end
    step(); step();
    total++;
    if (if_pc !== 32'h24 || misaligned_error !== 1'b1 || if_valid !== 1'b1) begin
      bad++;
      $display("FAIL mis_sticky got pc=%h err=%0b v=%0b exp pc=24 err=1 v=1", if_pc, misaligned_error, if_valid);
    end
    // An aligned redirect must not clear the sticky flag.
    redirect_valid = 1'b1; redirect_target = 32'h100;
    step();
    redirect_valid = 1'b0;
    total++;
    if (misaligned_error !== 1'b1 || read_address !== 10'd64) begin
      bad++;
      $display("FAIL mis_aligned_redir got err=%0b ra=%0d exp err=1 ra=64", misaligned_error, read_address);
    end
    do_reset();
    total++; if (misaligned_error !== 1'b0) begin bad++; $display("FAIL mis_clear got=%0b exp=0", misaligned_error); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'h1;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    total++;
    if (fetch_count !== 32'd7 || if_pc !== 32'h18 || misaligned_error !== 1'b1) begin
      bad++;
      $display("FAIL mid_pre got cnt=%0d pc=%h err=%0b exp cnt=7 pc=18 err=1", fetch_count, if_pc, misaligned_error);
    end
    reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h80; stall = 1'b1;
    step();
    reset = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
    total++;
    if (read_address !== 10'd0 || if_valid !== 1'b0 || fetch_count !== 32'd0 || misaligned_error !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset got ra=%0d v=%0b cnt=%0d err=%0b exp ra=0 v=0 cnt=0 err=0",
               read_address, if_valid, fetch_count, misaligned_error);
    end
    step();
    total++;
    if (if_pc !== 32'h0 || if_instruction !== 32'hC0DE_0000 || if_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_first got pc=%h ins=%h v=%0b exp pc=0 ins=c0de0000 v=1", if_pc, if_instruction, if_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    total++; if (read_address !== 10'h3FF) begin bad++; $display("FAIL wrap_raddr got=%h exp=3ff", read_address); end
    step();
    total++;
    if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0 || if_instruction !== 32'hC0DE_03FF || read_address !== 10'd0) begin
      bad++;
      $display("FAIL wrap_top got pc=%h p4=%h ins=%h ra=%0d exp pc=fffffffc p4=0 ins=c0de03ff ra=0",
               if_pc, if_pc_plus4, if_instruction, read_address);
    end
    step();
    total++;
    if (if_pc !== 32'h0 || if_instruction !== 32'hC0DE_0000) begin
      bad++;
      $display("FAIL wrap_zero got pc=%h ins=%h exp pc=0 ins=c0de0000", if_pc, if_instruction);
    end
    // Addresses past the memory size alias onto low words.
    redirect_valid = 1'b1; redirect_target = 32'h0000_1008;
    step();
    redirect_valid = 1'b0;
    total++; if (read_address !== 10'd2) begin bad++; $display("FAIL alias_raddr got=%0d exp=2", read_address); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE_0000 | i;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_and_stall();
    test_misaligned();
    test_reset_midstream();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
